// File: rtl/disp_pkg.sv
// Shared types and constants for the service dispatcher.
package disp_pkg;

    localparam int DT_SZ_DEF = 4;
    localparam int DC_W_DEF  = 8;

    // Value at which the drop counter stops counting (default width).
    localparam logic [DC_W_DEF-1:0] DROP_SAT = '1;

    // Customer record as it arrives on the input side.
    typedef struct packed {
        logic                 prio;
        logic [DT_SZ_DEF-1:0] svc_time;
        logic [DT_SZ_DEF-1:0] num;
    } cust_t;

    // A counter is IDLE when its remaining time is zero, SERVE otherwise.
    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } ctr_state_e;

endpackage

// File: rtl/svc_fifo.sv
// Shift-register FIFO: head always sits in slot 0, so the flattened
// contents are directly observable and unused slots read back as zero.
module svc_fifo #(
    parameter int DEPTH = 3,
    parameter int PTR_W = 2,
    parameter int W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [W-1:0]       din,
    output logic               full,
    output logic               empty,
    output logic [PTR_W:0]     count,
    output logic [W-1:0]       head,
    output logic [DEPTH*W-1:0] contents
);

    logic [W-1:0]   mem_reg   [DEPTH];
    logic [W-1:0]   mem_next  [DEPTH];
    logic [W-1:0]   shift_val [DEPTH];
    logic [PTR_W:0] count_reg;
    logic [PTR_W:0] count_next;
    logic [PTR_W:0] wr_idx;

    // A push lands behind the last entry that survives this cycle's pop.
    assign wr_idx = count_reg - (pop ? (PTR_W+1)'(1) : (PTR_W+1)'(0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            if (gi < DEPTH - 1) begin : g_mid
                assign shift_val[gi] = mem_reg[gi+1];
            end else begin : g_last
                assign shift_val[gi] = '0;
            end

            // Slot update: shift toward the head on pop, then write on push.
            always_comb begin
                mem_next[gi] = pop ? shift_val[gi] : mem_reg[gi];
                if (push && (wr_idx == (PTR_W+1)'(gi))) begin
                    mem_next[gi] = din;
                end
            end

            assign contents[gi*W +: W] = mem_reg[gi];
        end
    endgenerate

    // Occupancy follows push minus pop.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) count_next = count_reg + (PTR_W+1)'(1);
        if (pop && !push) count_next = count_reg - (PTR_W+1)'(1);
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= mem_next[i];
        end
    end

    assign full  = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem_reg[0];

endmodule

// File: rtl/service_dispatcher.sv
// Multi-counter service dispatcher: arrivals go to the lowest idle counter
// or into a bounded FIFO; counters count their service time down to zero.
// Optional feature macro: DISP_PRIO_EN adds a second FIFO for VIP arrivals
// that is always drained before the normal one.
module service_dispatcher
    import disp_pkg::*;
#(
    parameter int DT_SZ = DT_SZ_DEF,
    parameter int DEPTH = 3,
    parameter int PTR_W = 2,
    parameter int CNTER = 3,
    parameter int DC_W  = DC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DT_SZ-1:0]         in_num,
    input  logic [DT_SZ-1:0]         in_time,
    input  logic                     in_prio,
    output logic                     in_accept,
    output logic                     in_drop,
    output logic [CNTER*DT_SZ-1:0]   num_bus,
    output logic [CNTER*DT_SZ-1:0]   clk_bus,
    output logic [CNTER-1:0]         busy_bus,
    output logic [PTR_W:0]           q_count,
    output logic [DC_W-1:0]          drop_cnt,
    output logic [DEPTH*2*DT_SZ-1:0] qdbg
);

    localparam int EW  = 2 * DT_SZ;
    localparam int CIW = (CNTER > 1) ? $clog2(CNTER) : 1;

    logic [DT_SZ-1:0] rem_reg  [CNTER];
    logic [DT_SZ-1:0] rem_next [CNTER];
    logic [DT_SZ-1:0] num_reg  [CNTER];
    logic [DT_SZ-1:0] num_next [CNTER];
    ctr_state_e       st       [CNTER];

    logic             acc_reg, drop_reg;
    logic [DC_W-1:0]  drop_cnt_reg;

    logic             have1, have2;
    logic [CIW-1:0]   idx1, idx2;

    logic             n_push, n_pop, n_full, n_empty;
    logic [PTR_W:0]   n_count;
    logic [EW-1:0]    n_head;
    logic             v_push, v_pop, v_full, v_empty;
    logic [PTR_W:0]   v_count;
    logic [EW-1:0]    v_head;
    logic             arr_vip;

    logic             pop_any, empty_after, room, legal;
    logic             byp_have, do_byp, do_push, do_drop;
    logic [CIW-1:0]   byp_idx;
    logic [EW-1:0]    head_rec;

    genvar gi;
    generate
        for (gi = 0; gi < CNTER; gi++) begin : g_ctr
            assign st[gi]                       = (rem_reg[gi] == '0) ? IDLE : SERVE;
            assign num_bus[gi*DT_SZ +: DT_SZ]   = num_reg[gi];
            assign clk_bus[gi*DT_SZ +: DT_SZ]   = rem_reg[gi];
            assign busy_bus[gi]                 = (st[gi] == SERVE);
        end
    endgenerate

    // Priority encoder: lowest and second-lowest idle counters this cycle.
    always_comb begin
        have1 = 1'b0;
        have2 = 1'b0;
        idx1  = '0;
        idx2  = '0;
        for (int i = 0; i < CNTER; i++) begin
            if (st[i] == IDLE) begin
                if (!have1) begin
                    have1 = 1'b1;
                    idx1  = CIW'(i);
                end else if (!have2) begin
                    have2 = 1'b1;
                    idx2  = CIW'(i);
                end
            end
        end
    end

    svc_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(EW)) u_nfifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (n_push),
        .pop      (n_pop),
        .din      ({in_time, in_num}),
        .full     (n_full),
        .empty    (n_empty),
        .count    (n_count),
        .head     (n_head),
        .contents (qdbg)
    );

`ifdef DISP_PRIO_EN
    logic [DEPTH*EW-1:0] vip_contents_unused;

    svc_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(EW)) u_vfifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (v_push),
        .pop      (v_pop),
        .din      ({in_time, in_num}),
        .full     (v_full),
        .empty    (v_empty),
        .count    (v_count),
        .head     (v_head),
        .contents (vip_contents_unused)
    );

    assign arr_vip = in_prio;
`else
    // Without the VIP class the second queue is permanently empty.
    logic unused_prio_sigs;

    assign v_full           = 1'b0;
    assign v_empty          = 1'b1;
    assign v_count          = '0;
    assign v_head           = '0;
    assign arr_vip          = 1'b0;
    assign unused_prio_sigs = ^{in_prio, v_push};
`endif

    // Dispatch decision: pop to the first free counter, then bypass,
    // enqueue or drop the arrival.
    always_comb begin
        v_pop    = have1 && !v_empty;
        n_pop    = have1 && v_empty && !n_empty;
        pop_any  = v_pop || n_pop;
        head_rec = v_pop ? v_head : n_head;

        empty_after = (n_empty || (n_pop && n_count == (PTR_W+1)'(1))) &&
                      (v_empty || (v_pop && v_count == (PTR_W+1)'(1)));

        byp_have = pop_any ? have2 : have1;
        byp_idx  = pop_any ? idx2 : idx1;

        legal   = in_valid && (in_time != '0);
        do_byp  = legal && empty_after && byp_have;
        room    = arr_vip ? (!v_full || v_pop) : (!n_full || n_pop);
        do_push = legal && !do_byp && room;
        do_drop = in_valid && !do_byp && !do_push;

        n_push = do_push && !arr_vip;
        v_push = do_push && arr_vip;
    end

    // Counter next state: count down, clear the number on reaching zero,
    // and load the popped head or the bypassed arrival.
    always_comb begin
        for (int i = 0; i < CNTER; i++) begin
            rem_next[i] = (st[i] == SERVE) ? rem_reg[i] - DT_SZ'(1) : '0;
            num_next[i] = (rem_reg[i] > DT_SZ'(1)) ? num_reg[i] : '0;
            if (pop_any && idx1 == CIW'(i)) begin
                rem_next[i] = head_rec[EW-1:DT_SZ];
                num_next[i] = head_rec[DT_SZ-1:0];
            end
            if (do_byp && byp_idx == CIW'(i)) begin
                rem_next[i] = in_time;
                num_next[i] = in_num;
            end
        end
    end

    // Counter registers, arrival outcome pulses and saturating drop count.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < CNTER; i++) begin
                rem_reg[i] <= '0;
                num_reg[i] <= '0;
            end
            acc_reg      <= 1'b0;
            drop_reg     <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            for (int i = 0; i < CNTER; i++) begin
                rem_reg[i] <= rem_next[i];
                num_reg[i] <= num_next[i];
            end
            acc_reg  <= do_byp || do_push;
            drop_reg <= do_drop;
            if (do_drop && !(&drop_cnt_reg)) begin
                drop_cnt_reg <= drop_cnt_reg + DC_W'(1);
            end
        end
    end

    assign in_accept = acc_reg;
    assign in_drop   = drop_reg;
    assign drop_cnt  = drop_cnt_reg;
    assign q_count   = n_count + v_count;

endmodule

// File: tb/tb_service_dispatcher.sv
// Self-checking bench for service_dispatcher with a queue-based reference
// model. Honours DISP_PRIO_EN the same way the design does.
module tb_service_dispatcher;

    localparam int DT_SZ = 4;
    localparam int DEPTH = 3;
    localparam int PTR_W = 2;
    localparam int CNTER = 3;
    localparam int DC_W  = 8;
`ifdef DISP_PRIO_EN
    localparam bit USE_PRIO = 1'b1;
`else
    localparam bit USE_PRIO = 1'b0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic [DT_SZ-1:0]         in_num;
    logic [DT_SZ-1:0]         in_time;
    logic                     in_prio;
    logic                     in_accept;
    logic                     in_drop;
    logic [CNTER*DT_SZ-1:0]   num_bus;
    logic [CNTER*DT_SZ-1:0]   clk_bus;
    logic [CNTER-1:0]         busy_bus;
    logic [PTR_W:0]           q_count;
    logic [DC_W-1:0]          drop_cnt;
    logic [DEPTH*2*DT_SZ-1:0] qdbg;

    service_dispatcher #(
        .DT_SZ(DT_SZ), .DEPTH(DEPTH), .PTR_W(PTR_W), .CNTER(CNTER), .DC_W(DC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_num(in_num),
        .in_time(in_time), .in_prio(in_prio), .in_accept(in_accept),
        .in_drop(in_drop), .num_bus(num_bus), .clk_bus(clk_bus),
        .busy_bus(busy_bus), .q_count(q_count), .drop_cnt(drop_cnt), .qdbg(qdbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct { int num; int tm; } cust_s;
    cust_s nq[$];
    cust_s vq[$];
    int    m_rem [CNTER];
    int    m_num [CNTER];
    bit    m_acc, m_drop;
    int    m_dc;

    function automatic void model_reset();
        nq.delete();
        vq.delete();
        for (int i = 0; i < CNTER; i++) begin
            m_rem[i] = 0;
            m_num[i] = 0;
        end
        m_acc  = 0;
        m_drop = 0;
        m_dc   = 0;
    endfunction

    function automatic void model_step(input bit v, input int num, input int tm, input bit pr);
        int    fr[$];
        int    fi;
        cust_s c;
        int    nr [CNTER];
        int    nn [CNTER];
        bit    vip;
        for (int i = 0; i < CNTER; i++) if (m_rem[i] == 0) fr.push_back(i);
        for (int i = 0; i < CNTER; i++) begin
            nr[i] = (m_rem[i] > 0) ? m_rem[i] - 1 : 0;
            nn[i] = (nr[i] == 0) ? 0 : m_num[i];
        end
        fi     = 0;
        m_acc  = 0;
        m_drop = 0;
        if (fr.size() > 0 && (vq.size() > 0 || nq.size() > 0)) begin
            if (vq.size() > 0) c = vq.pop_front();
            else               c = nq.pop_front();
            nr[fr[0]] = c.tm;
            nn[fr[0]] = c.num;
            fi = 1;
        end
        if (v) begin
            vip  = USE_PRIO && pr;
            c.num = num;
            c.tm  = tm;
            if (tm == 0) m_drop = 1;
            else if (vq.size() == 0 && nq.size() == 0 && fi < fr.size()) begin
                nr[fr[fi]] = tm;
                nn[fr[fi]] = num;
                m_acc = 1;
            end else if (vip && vq.size() < DEPTH) begin
                vq.push_back(c);
                m_acc = 1;
            end else if (!vip && nq.size() < DEPTH) begin
                nq.push_back(c);
                m_acc = 1;
            end else m_drop = 1;
        end
        if (m_drop && m_dc < 255) m_dc++;
        for (int i = 0; i < CNTER; i++) begin
            m_rem[i] = nr[i];
            m_num[i] = nn[i];
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    logic [CNTER*DT_SZ-1:0]   e_num, e_clk;
    logic [CNTER-1:0]         e_busy;
    logic [DEPTH*2*DT_SZ-1:0] e_qdbg;

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            e_num  = '0;
            e_clk  = '0;
            e_busy = '0;
            e_qdbg = '0;
            for (int i = 0; i < CNTER; i++) begin
                e_num[i*DT_SZ +: DT_SZ] = m_num[i][DT_SZ-1:0];
                e_clk[i*DT_SZ +: DT_SZ] = m_rem[i][DT_SZ-1:0];
                e_busy[i]               = (m_rem[i] != 0);
            end
            for (int s = 0; s < nq.size(); s++) begin
                e_qdbg[s*2*DT_SZ +: 2*DT_SZ] = {nq[s].tm[DT_SZ-1:0], nq[s].num[DT_SZ-1:0]};
            end
            chk("in_accept", 64'(in_accept), 64'(m_acc));
            chk("in_drop",   64'(in_drop),   64'(m_drop));
            chk("num_bus",   64'(num_bus),   64'(e_num));
            chk("clk_bus",   64'(clk_bus),   64'(e_clk));
            chk("busy_bus",  64'(busy_bus),  64'(e_busy));
            chk("q_count",   64'(q_count),   64'(nq.size() + vq.size()));
            chk("drop_cnt",  64'(drop_cnt),  64'(m_dc));
            chk("qdbg",      64'(qdbg),      64'(e_qdbg));
        end
    end

    // ---------------- stimulus ----------------
    // Drive at a falling edge, let the model take the rising edge, return
    // at the next falling edge.
    task automatic send(input bit v, input int num, input int tm, input bit pr);
        in_valid = v;
        in_num   = num[DT_SZ-1:0];
        in_time  = tm[DT_SZ-1:0];
        in_prio  = pr;
        @(posedge clk);
        model_step(v, num, tm, pr);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 0, 0, 1'b0);
    endtask

    typedef struct { bit v; int num; int tm; bit pr; } vec_s;
    vec_s mix[$];

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_num   = '0;
        in_time  = '0;
        in_prio  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_num_bus",  64'(num_bus),  64'h0);
        chk("rst_clk_bus",  64'(clk_bus),  64'h0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
        chk("rst_accept",   64'(in_accept), 64'h0);
        rst_n    = 1'b0;
        check_en = 1'b1;
        idle(2);

        // Three direct placements.
        send(1, 1, 8, 0);
        send(1, 2, 8, 0);
        send(1, 3, 8, 0);
        chk("lit_num_bus_123", 64'(num_bus), 64'h321);
        chk("lit_clk_bus_876", 64'(clk_bus), 64'h876);
        chk("lit_q_empty",     64'(q_count), 64'h0);

        // Fill the queue, overflow drops customer 7.
        send(1, 4, 1, 0);
        send(1, 5, 5, 0);
        send(1, 6, 2, 0);
        send(1, 7, 3, 0);
        chk("lit_q_full",    64'(q_count),  64'h3);
        chk("lit_drop7",     64'(in_drop),  64'h1);
        chk("lit_drop_cnt1", 64'(drop_cnt), 64'h1);
        chk("lit_qdbg456",   64'(qdbg),     64'h265514);

        // Counter 0 frees and then takes customer 4 with one cycle of service.
        idle(2);
        chk("lit_c0_idle", 64'(num_bus[3:0]), 64'h0);
        idle(1);
        chk("lit_c0_num4", 64'(num_bus[3:0]), 64'h4);
        chk("lit_c0_clk1", 64'(clk_bus[3:0]), 64'h1);
        chk("lit_q_two",   64'(q_count),      64'h2);
        idle(17);
        chk("lit_q_drained", 64'(q_count), 64'h0);

        // Illegal zero service time, then drop counter saturation.
        send(1, 8, 0, 0);
        chk("lit_zero_drop",  64'(in_drop),  64'h1);
        chk("lit_drop_cnt2",  64'(drop_cnt), 64'h2);
        chk("lit_no_service", 64'(num_bus),  64'h0);
        for (int k = 0; k < 300; k++) send(1, 9, 0, 0);
        chk("lit_drop_sat", 64'(drop_cnt), 64'hff);
        idle(1);

        // VIP ordering with all counters busy.
        send(1, 1, 6, 0);
        send(1, 2, 6, 0);
        send(1, 3, 6, 0);
        send(1, 4, 2, 0);
        send(1, 5, 3, 0);
        send(1, 6, 4, 1);
        idle(2);
        chk("lit_first_pop", 64'(num_bus[3:0]), USE_PRIO ? 64'h6 : 64'h4);
        idle(20);

        // Mixed directed vectors: short times, bypass, pop and push together.
        mix = '{
            '{1, 10, 2, 0}, '{1, 11, 1, 0}, '{1, 12, 1, 1}, '{1, 13, 2, 0},
            '{1, 14, 1, 0}, '{0, 0, 0, 0},  '{1, 15, 3, 1}, '{1, 3, 1, 0},
            '{1, 4, 2, 1},  '{1, 5, 1, 0},  '{1, 6, 15, 1}, '{1, 7, 15, 0},
            '{1, 8, 15, 1}, '{1, 9, 1, 1},  '{1, 1, 1, 1},  '{1, 2, 1, 1},
            '{1, 3, 1, 1},  '{1, 4, 1, 0}
        };
        foreach (mix[k]) send(mix[k].v, mix[k].num, mix[k].tm, mix[k].pr);
        idle(20);

        // Asynchronous reset in the middle of service.
        send(1, 7, 9, 0);
        send(1, 8, 9, 0);
        check_en = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        chk("lit_arst_num_bus", 64'(num_bus),  64'h0);
        chk("lit_arst_clk_bus", 64'(clk_bus),  64'h0);
        chk("lit_arst_busy",    64'(busy_bus), 64'h0);
        chk("lit_arst_qcount",  64'(q_count),  64'h0);
        chk("lit_arst_dropcnt", 64'(drop_cnt), 64'h0);
        chk("lit_arst_accept",  64'(in_accept), 64'h0);
        model_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        check_en = 1'b1;
        idle(2);
        send(1, 9, 2, 0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
